core_hazard_ctrl: RTL and testbench

CORE_HAZARD_CTRL -- requirements
Module: core_hazard_ctrl

---
 rtl/core_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_core_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/core_hazard_ctrl.sv
// Decode-stage hazard controller: RAW scoreboard, stall/issue/flush control and stall-cycle counter.
// Define HAZARD_FWD_EN when EX/MEM forwarding exists, so only load-use dependencies stall.
module core_hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic        c_reg1_memread_i,
    input  logic        c_reg2_memread_i,
    input  logic [4:0]  reg_araddr1_i,
    input  logic [4:0]  reg_araddr2_i,
    input  logic        c_reg_awvalid_i,
    input  logic [4:0]  reg_awaddr_i,
    input  logic        c_isload_i,
    input  logic        mem_ldvalid_i,
    input  logic [4:0]  mem_ldaddr_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_awaddr_i,
    input  logic        ex_flush_i,
    output logic        stall_o,
    output logic        id_issue_o,
    output logic        flush_ifid_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] loadpend_q, loadpend_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] busy;
    logic        hazard;
    logic        issue;
    logic        set_rd;

    // Results retiring this cycle are already visible to ID (write-through regfile / forwarding)
    always_comb begin
`ifdef HAZARD_FWD_EN
        busy = loadpend_q;
        if (mem_ldvalid_i) busy[mem_ldaddr_i] = 1'b0;
`else
        busy = pending_q;
`endif
        if (wb_valid_i) busy[wb_awaddr_i] = 1'b0;
        busy[0] = 1'b0;
    end

    assign hazard = id_valid_i &&
                    ((c_reg1_memread_i && busy[reg_araddr1_i]) ||
                     (c_reg2_memread_i && busy[reg_araddr2_i]));
    assign issue  = id_valid_i && !hazard && (state_q != S_FLUSH) && !ex_flush_i;
    assign set_rd = issue && c_reg_awvalid_i && (reg_awaddr_i != 5'd0);

    always_comb begin
        state_d = state_q;
        if (ex_flush_i) begin
            state_d = S_FLUSH;
        end else begin
            unique case (state_q)
                S_RUN:   state_d = hazard ? S_STALL : S_RUN;
                S_STALL: state_d = hazard ? S_STALL : S_RUN;
                S_FLUSH: state_d = S_RUN;
                default: state_d = S_RUN;
            endcase
        end
    end

    // Clears are applied before sets so a newly issued writer keeps its bit
    always_comb begin
        pending_d  = pending_q;
        loadpend_d = loadpend_q;
        if (wb_valid_i)    pending_d[wb_awaddr_i]   = 1'b0;
        if (mem_ldvalid_i) loadpend_d[mem_ldaddr_i] = 1'b0;
        if (set_rd) begin
            pending_d[reg_awaddr_i] = 1'b1;
            if (c_isload_i) loadpend_d[reg_awaddr_i] = 1'b1;
        end
        pending_d[0]  = 1'b0;
        loadpend_d[0] = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_RUN;
            pending_q   <= 32'd0;
            loadpend_q  <= 32'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            loadpend_q  <= loadpend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset gates the combinational outputs so a stall is dropped the moment reset rises
    assign stall_o      = !rst_i && hazard && !ex_flush_i;
    assign id_issue_o   = !rst_i && issue;
    assign flush_ifid_o = !rst_i && (ex_flush_i || (state_q == S_FLUSH));
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Directed self-checking bench for core_hazard_ctrl; expectations are hand-derived per cycle.
// Covers the default build and, when HAZARD_FWD_EN is defined, the load-use-only variant.
module tb_core_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        idValid, rd1En, rd2En, wrEn, isLoad;
    logic [4:0]  rdAddr1, rdAddr2, wrAddr;
    logic        memLdValid, wbValid, exFlush;
    logic [4:0]  memLdAddr, wbAddr;
    logic        stall, idIssue, flushIfid;
    logic [15:0] stallCnt;

    int          total = 0;
    int          bad = 0;
    logic [15:0] expCnt;
    bit          stallExp;

    always #5 clk = ~clk;

    core_hazard_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .id_valid_i       (idValid),
        .c_reg1_memread_i (rd1En),
        .c_reg2_memread_i (rd2En),
        .reg_araddr1_i    (rdAddr1),
        .reg_araddr2_i    (rdAddr2),
        .c_reg_awvalid_i  (wrEn),
        .reg_awaddr_i     (wrAddr),
        .c_isload_i       (isLoad),
        .mem_ldvalid_i    (memLdValid),
        .mem_ldaddr_i     (memLdAddr),
        .wb_valid_i       (wbValid),
        .wb_awaddr_i      (wbAddr),
        .ex_flush_i       (exFlush),
        .stall_o          (stall),
        .id_issue_o       (idIssue),
        .flush_ifid_o     (flushIfid),
        .stall_cnt_o      (stallCnt)
    );

    // Single comparison point: counts every check and reports mismatches
    task checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task applyStimulus(input bit idv, input bit r1, input logic [4:0] a1, input bit r2,
                       input logic [4:0] a2, input bit wr, input logic [4:0] rd, input bit ld);
        idValid = idv; rd1En = r1; rdAddr1 = a1; rd2En = r2; rdAddr2 = a2;
        wrEn = wr; wrAddr = rd; isLoad = ld;
    endtask

    task applySideband(input bit wbv, input logic [4:0] wba, input bit mlv,
                       input logic [4:0] mla, input bit fl);
        wbValid = wbv; wbAddr = wba; memLdValid = mlv; memLdAddr = mla; exFlush = fl;
    endtask

    // Reference stall counter advances on the edge that closes a cycle expected to stall
    task nextCycle;
        @(posedge clk);
        if (stallExp && expCnt != 16'hFFFF) expCnt++;
        #1;
    endtask

    task expectCtl(input string tag, input bit s, input bit iss, input bit fl);
        #3;
        checkOutput({tag, ".stall"}, {15'd0, stall}, {15'd0, s});
        checkOutput({tag, ".issue"}, {15'd0, idIssue}, {15'd0, iss});
        checkOutput({tag, ".flush"}, {15'd0, flushIfid}, {15'd0, fl});
        stallExp = s;
    endtask

    initial begin
        stallExp = 0;
        expCnt   = 16'd0;
        rst      = 1'b1;
        // Reset with hostile inputs: everything must still read zero
        applyStimulus(1, 1, 5'd3, 1, 5'd4, 1, 5'd3, 0);
        applySideband(0, 5'd0, 0, 5'd0, 1);
        #3;
        expectCtl("rst", 0, 0, 0);
        checkOutput("rst.cnt", stallCnt, 16'd0);
        applySideband(0, 5'd0, 0, 5'd0, 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef HAZARD_FWD_EN
        nextCycle; applyStimulus(1, 1, 5'd1, 0, 5'd0, 1, 5'd7, 1); expectCtl("lw", 0, 1, 0);
        nextCycle; applyStimulus(1, 1, 5'd7, 1, 5'd7, 1, 5'd8, 0); expectCtl("lu0", 1, 0, 0);
        nextCycle; applySideband(0, 5'd0, 1, 5'd7, 0);            expectCtl("lu_ld", 0, 1, 0);
        checkOutput("lu.cnt", stallCnt, 16'd1);
`else
        nextCycle; applyStimulus(1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 0); expectCtl("addi", 0, 1, 0);
        nextCycle; applyStimulus(1, 1, 5'd5, 1, 5'd1, 1, 5'd6, 0); expectCtl("raw0", 1, 0, 0);
        nextCycle;                                                 expectCtl("raw1", 1, 0, 0);
        nextCycle; applySideband(1, 5'd5, 0, 5'd0, 0);            expectCtl("raw_wb", 0, 1, 0);
        checkOutput("raw.cnt", stallCnt, 16'd2);
`endif
        // Retire everything outstanding from the dependency test
        for (int r = 5; r <= 8; r++) begin
            nextCycle;
            applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
            applySideband(1, r[4:0], 1, r[4:0], 0);
        end

        nextCycle; applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd0, 1);
        applySideband(0, 5'd0, 0, 5'd0, 0);                        expectCtl("wx0", 0, 1, 0);
        nextCycle; applyStimulus(1, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0); expectCtl("rx0", 0, 1, 0);

        // New writer of x9 issued while an older x9 write retires: set must win
        nextCycle; applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd9, 1);
        applySideband(1, 5'd9, 1, 5'd9, 0);                        expectCtl("x9set", 0, 1, 0);
        nextCycle; applyStimulus(1, 1, 5'd9, 0, 5'd0, 0, 5'd0, 0);
        applySideband(0, 5'd0, 0, 5'd0, 0);                        expectCtl("x9busy", 1, 0, 0);
        nextCycle; applySideband(1, 5'd9, 1, 5'd9, 0);            expectCtl("x9wt", 0, 1, 0);
        nextCycle; applySideband(0, 5'd0, 0, 5'd0, 0);            expectCtl("x9clr", 0, 1, 0);

        // Flush arriving while stalled
        nextCycle; applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd10, 1); expectCtl("x10set", 0, 1, 0);
        nextCycle; applyStimulus(1, 0, 5'd0, 1, 5'd10, 0, 5'd0, 0); expectCtl("st0", 1, 0, 0);
        nextCycle;                                                  expectCtl("st1", 1, 0, 0);
        nextCycle; applySideband(0, 5'd0, 0, 5'd0, 1);             expectCtl("fl0", 0, 0, 1);
        nextCycle; applyStimulus(1, 1, 5'd1, 0, 5'd0, 0, 5'd0, 0);
        applySideband(0, 5'd0, 0, 5'd0, 0);                         expectCtl("fl1", 0, 0, 1);
        nextCycle; applyStimulus(1, 0, 5'd0, 1, 5'd10, 0, 5'd0, 0); expectCtl("postfl", 1, 0, 0);

        // Long stall: counter tracks, then saturates
        repeat (1000) nextCycle;
        #3;
        checkOutput("cnt1000", stallCnt, expCnt);
        repeat (69000) nextCycle;
        #3;
        checkOutput("cntsat", stallCnt, 16'hFFFF);
        checkOutput("sat.stall", {15'd0, stall}, 16'd1);

        // Asynchronous reset in the middle of the stall
        rst = 1'b1;
        #1;
        checkOutput("arst.stall", {15'd0, stall}, 16'd0);
        checkOutput("arst.issue", {15'd0, idIssue}, 16'd0);
        checkOutput("arst.cnt", stallCnt, 16'd0);
        applySideband(0, 5'd0, 0, 5'd0, 1);
        #1;
        checkOutput("arst.flush", {15'd0, flushIfid}, 16'd0);
        applySideband(0, 5'd0, 0, 5'd0, 0);
        stallExp = 0;
        expCnt   = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        nextCycle; expectCtl("postrst", 0, 1, 0);
        checkOutput("postrst.cnt", stallCnt, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
